// File: rtl/axi_lite_rw_selftest_master.sv
// AXI4-Lite master that writes NUM_VECTORS pattern words, reads each back and compares.
// Optional handshake watchdog enabled by defining AXI_SELFTEST_WATCHDOG_EN.
module axi_lite_rw_selftest_master #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           NUM_VECTORS    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           ADDR_STRIDE    = 4,
  parameter logic [31:0]           PATTERN_SEED   = 32'h0101FFFF,
  parameter logic [31:0]           PATTERN_INC    = 32'h9E3779B9,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic [7:0]              first_err_idx,
  output logic [2:0]              state_dbg,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 256 || (DATA_WIDTH != 32 && DATA_WIDTH != 64)
      || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_lite_rw_selftest_master: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_CHECK, S_DONE
  } state_t;

  localparam logic [7:0]            LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [DATA_WIDTH-1:0] SEED     = DATA_WIDTH'(PATTERN_SEED);
  localparam logic [DATA_WIDTH-1:0] INC      = DATA_WIDTH'(PATTERN_INC);

  state_t                  state;
  logic [7:0]              idx;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wr_err;
  logic                    rd_err;
  logic                    aw_fire;
  logic                    w_fire;
  logic                    aw_clear;
  logic                    w_clear;

  // Handshake rule: a transfer happens on a rising edge where VALID and READY are both high;
  // VALID stays high with stable payload until then, and every READY here is a pure register.
  assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;
  assign aw_clear = !M_AXI_AWVALID || aw_fire;
  assign w_clear  = !M_AXI_WVALID || w_fire;

  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;
  assign state_dbg    = state;

`ifdef AXI_SELFTEST_WATCHDOG_EN
  state_t      wd_state;
  logic [31:0] wd_cnt;
  logic [31:0] wd_now;
  logic        wd_expired;

  // wd_now counts completed cycles spent in the current state, restarting on every entry.
  assign wd_now     = (state != wd_state) ? 32'd0 : wd_cnt;
  assign wd_expired = (state inside {S_WR, S_WRESP, S_RADDR, S_RDATA})
                      && (wd_now == TIMEOUT_CYCLES - 1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wd_state <= S_IDLE;
      wd_cnt   <= '0;
    end else begin
      wd_state <= state;
      wd_cnt   <= wd_now + 32'd1;
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      idx           <= '0;
      addr          <= BASE_ADDR;
      M_AXI_WDATA   <= SEED;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= 8'hFF;
      wr_err        <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
`ifdef AXI_SELFTEST_WATCHDOG_EN
      if (wd_expired) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (first_err_idx == 8'hFF) first_err_idx <= idx;
        state <= S_DONE;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            idx           <= '0;
            addr          <= BASE_ADDR;
            M_AXI_WDATA   <= SEED;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 8'hFF;
            state         <= S_WR;
          end
        end
        S_WR: begin
          if (aw_fire) M_AXI_AWVALID <= 1'b0;
          if (w_fire) M_AXI_WVALID <= 1'b0;
          if (aw_clear && w_clear) begin
            M_AXI_BREADY <= 1'b1;
            state        <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            wr_err        <= (M_AXI_BRESP != 2'b00);
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b1;
            state         <= S_RADDR;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rd_err       <= (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != M_AXI_WDATA);
            M_AXI_RREADY <= 1'b0;
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A vector contributes at most one error no matter how many checks it failed.
          if (wr_err || rd_err) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (first_err_idx == 8'hFF) first_err_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx           <= idx + 8'd1;
            addr          <= addr + STRIDE;
            M_AXI_WDATA   <= M_AXI_WDATA + INC;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 8'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rw_selftest_master.sv
// Self-checking bench: memory slave with configurable delays/faults and a vector-list reference model.
`timescale 1ns/1ps
module tb_axi_lite_rw_selftest_master;
  localparam int          NV     = 4;
  localparam int          STRIDE = 4;
  localparam logic [31:0] SEED   = 32'h0101FFFF;
  localparam logic [31:0] INC    = 32'h9E3779B9;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic start = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        busy, done, pass;
  logic [7:0]  err_count, first_err_idx;
  logic [2:0]  state_dbg;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  axi_lite_rw_selftest_master dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .state_dbg(state_dbg),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          exp_err;
  logic [7:0]  exp_first;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_commit(input logic [31:0] a, input logic [31:0] d);
    check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      check("wr_addr", 64'(a), 64'(exp_addr_q.pop_front()));
      check("wr_data", 64'(d), 64'(exp_q.pop_front()));
      check("wr_strb_prot", {57'd0, awprot, wstrb}, {57'd0, 3'b000, 4'hF});
    end
  endtask

  // ---------------- memory slave (acts on falling edges) ----------------
  logic [31:0] mem [logic [31:0]];
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit          corrupt_en = 0, berr_en = 0, rerr_en = 0;
  logic [31:0] corrupt_addr = '0, berr_addr = '0, rerr_addr = '0;
  bit          have_aw = 0, have_w = 0;
  logic [31:0] aw_addr_l = '0, w_data_l = '0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit          s_awv = 0, s_wv = 0, s_br = 0, s_arv = 0, s_rr = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;

  always @(negedge ACLK) begin
    if (ARESET) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    end else begin
      // transfers that completed on the rising edge just past
      if (s_awv && awready) begin have_aw = 1; aw_addr_l = s_awaddr; awready = 0; aw_cnt = 0; end
      if (s_wv && wready) begin have_w = 1; w_data_l = s_wdata; wready = 0; w_cnt = 0; end
      if (s_br && bvalid) bvalid = 0;
      if (s_rr && rvalid) rvalid = 0;
      if (s_arv && arready) begin
        arready = 0; ar_cnt = 0;
        rdata = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
        if (corrupt_en && s_araddr == corrupt_addr) rdata[0] = ~rdata[0];
        rresp = (rerr_en && s_araddr == rerr_addr) ? 2'b10 : 2'b00;
        rvalid = 1;
      end
      if (have_aw && have_w && !bvalid) begin
        mem[aw_addr_l] = w_data_l;
        write_commit(aw_addr_l, w_data_l);
        bresp = (berr_en && aw_addr_l == berr_addr) ? 2'b10 : 2'b00;
        bvalid = 1; have_aw = 0; have_w = 0;
      end
      if (awvalid && !awready && !have_aw) begin
        if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
      end
      if (wvalid && !wready && !have_w) begin
        if (w_cnt >= w_delay) wready = 1; else w_cnt++;
      end
      if (arvalid && !arready && !rvalid) begin
        if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
      end
    end
    s_awv = awvalid; s_wv = wvalid; s_br = bready; s_arv = arvalid; s_rr = rready;
    s_awaddr = awaddr; s_wdata = wdata; s_araddr = araddr;
  end

  // ---------------- reference model and driver tasks ----------------
  function automatic logic [31:0] vec_addr(input int i);
    return 32'(i * STRIDE);
  endfunction

  function automatic logic [31:0] vec_data(input int i);
    return SEED + INC * 32'(i);
  endfunction

  task automatic set_slave(input int awd, input int wd, input int ard,
                           input bit ce, input int ci, input bit be, input int bi,
                           input bit re, input int ri);
    aw_delay = awd; w_delay = wd; ar_delay = ard;
    corrupt_en = ce; corrupt_addr = vec_addr(ci);
    berr_en = be; berr_addr = vec_addr(bi);
    rerr_en = re; rerr_addr = vec_addr(ri);
  endtask

  task automatic prepare();
    exp_q.delete(); exp_addr_q.delete();
    exp_err = 0; exp_first = 8'hFF;
    for (int i = 0; i < NV; i++) begin
      logic [31:0] a;
      a = vec_addr(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(vec_data(i));
      if ((corrupt_en && a == corrupt_addr) || (berr_en && a == berr_addr) ||
          (rerr_en && a == rerr_addr)) begin
        if (exp_first == 8'hFF) exp_first = 8'(i);
        exp_err++;
      end
    end
  endtask

  task automatic start_run(input string name);
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    check({name, ".busy_after_start"}, 64'(busy), 64'd1);
    check({name, ".done_cleared"}, 64'(done), 64'd0);
    check({name, ".err_cleared"}, 64'(err_count), 64'd0);
    check({name, ".first_cleared"}, 64'(first_err_idx), 64'hFF);
  endtask

  task automatic finish_run(input string name);
    int n;
    repeat (2) @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    check({name, ".done"}, 64'(done), 64'd1);
    check({name, ".busy_low"}, 64'(busy), 64'd0);
    check({name, ".pass"}, 64'(pass), 64'(exp_err == 0));
    check({name, ".err_count"}, 64'(err_count), 64'(exp_err));
    check({name, ".first_err_idx"}, 64'(first_err_idx), 64'(exp_first));
    check({name, ".all_writes_seen"}, 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < NV; i++)
      check({name, ".mem"}, mem.exists(vec_addr(i)) ? 64'(mem[vec_addr(i)]) : 64'hDEAD_0000_0000,
            64'(vec_data(i)));
    repeat (3) @(negedge ACLK);
    check({name, ".done_held"}, 64'(done), 64'd1);
    check({name, ".pass_held"}, 64'(pass), 64'(exp_err == 0));
  endtask

  task automatic full_run(input string name);
    prepare();
    start_run(name);
    finish_run(name);
  endtask

  // ---------------- directed and randomized sequence ----------------
  initial begin
    int seen, n;
    bit prev;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.pass", 64'(pass), 64'd0);
    check("reset.err_count", 64'(err_count), 64'd0);
    check("reset.first_err_idx", 64'(first_err_idx), 64'hFF);
    check("reset.valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);

    set_slave(0, 0, 0, 0, 0, 0, 0, 0, 0);
    full_run("zero_wait");

    set_slave(3, 5, 0, 0, 0, 0, 0, 0, 0);
    full_run("aw_w_delay");

    set_slave(0, 0, 0, 1, 2, 0, 0, 0, 0);
    full_run("corrupt_0x8");

    set_slave(0, 0, 0, 0, 0, 1, 0, 1, 0);
    full_run("resp_err_0x0");

    // reset while vector 1 waits for read data
    set_slave(0, 0, 0, 0, 0, 0, 0, 0, 0);
    prepare();
    start_run("mid_reset");
    seen = 0; prev = 0; n = 0;
    while (seen < 2 && n < 500) begin
      @(negedge ACLK);
      n++;
      if (rready && !prev) seen++;
      prev = rready;
    end
    check("mid_reset.reached_rdata1", 64'(seen), 64'd2);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_reset.valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("mid_reset.busy", 64'(busy), 64'd0);
    check("mid_reset.done", 64'(done), 64'd0);
    check("mid_reset.first_err_idx", 64'(first_err_idx), 64'hFF);
    @(negedge ACLK);
    ARESET = 1'b0;
    full_run("after_reset");

    for (int r = 0; r < 6; r++) begin
      set_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), $urandom_range(0, NV - 1),
                1'($urandom_range(0, 1)), $urandom_range(0, NV - 1),
                1'($urandom_range(0, 1)), $urandom_range(0, NV - 1));
      full_run($sformatf("random%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
